// File: rtl/cache_rd_arbiter.sv
// Read-channel arbiter between icache and dcache in front of a single-read-port memory bridge.
// One transaction in flight; dcache priority bounded by a starvation counter; uncached reads wait for write-buffer drain.
module cache_rd_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        i_rd_req,
  input  logic [2:0]  i_rd_type,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,

  input  logic        d_rd_req,
  input  logic [2:0]  d_rd_type,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,

  output logic        m_rd_req,
  output logic [2:0]  m_rd_type,
  output logic [31:0] m_rd_addr,
  input  logic        m_rd_rdy,
  input  logic        m_ret_valid,
  input  logic        m_ret_last,
  input  logic [31:0] m_ret_data,

  input  logic        wr_buf_empty,
  output logic        busy,

  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_grant,
  output logic [7:0]  dbg_starve_cnt
);

  // Handshake: a request is transferred on the cycle where req && rdy are both high;
  // the requester holds req/type/addr stable until it sees rdy. Return beats carry no
  // back-pressure: every cycle with ret_valid high is one beat, ret_last marks the final one.

  localparam logic [2:0] TYPE_LINE = 3'b100;
  localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_e;

  state_e     state_q, state_d;
  grant_e     grant_q, grant_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       busy_q, busy_d;

  logic i_elig;
  logic d_elig;
  logic pick_data;

  // Uncached reads may bypass buffered writes in the bridge, so they only compete
  // once the write buffer is empty; line refills are always safe to issue.
  assign i_elig    = i_rd_req && ((i_rd_type == TYPE_LINE) || wr_buf_empty);
  assign d_elig    = d_rd_req && ((d_rd_type == TYPE_LINE) || wr_buf_empty);
  assign pick_data = d_elig && (!i_elig || (starve_cnt_q < LIMIT));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_elig || d_elig) begin
          state_d = ST_REQ;
          if (pick_data) begin
            grant_d = GNT_DATA;
            if (i_rd_req) begin
              starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 8'd1;
            end else begin
              starve_cnt_d = 8'd0;
            end
          end else begin
            grant_d      = GNT_INST;
            starve_cnt_d = 8'd0;
          end
        end
      end
      ST_REQ: begin
        if (grant_q == GNT_NONE) begin
          state_d = ST_IDLE;
        end else if (m_rd_req && m_rd_rdy) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (grant_q == GNT_NONE) begin
          state_d = ST_IDLE;
        end else if (m_ret_valid && m_ret_last) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      starve_cnt_q <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // Request and return muxes; everything outside the owning phase is forced to zero,
  // which is also what drops stray return beats seen in IDLE or REQ.
  always_comb begin
    m_rd_req    = 1'b0;
    m_rd_type   = 3'b000;
    m_rd_addr   = 32'h0;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    i_ret_data  = 32'h0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    d_ret_data  = 32'h0;

    if (state_q == ST_REQ) begin
      case (grant_q)
        GNT_INST: begin
          m_rd_req  = i_rd_req;
          m_rd_type = i_rd_type;
          m_rd_addr = i_rd_addr;
          i_rd_rdy  = m_rd_rdy;
        end
        GNT_DATA: begin
          m_rd_req  = d_rd_req;
          m_rd_type = d_rd_type;
          m_rd_addr = d_rd_addr;
          d_rd_rdy  = m_rd_rdy;
        end
        default: ;
      endcase
    end

    if (state_q == ST_RESP) begin
      case (grant_q)
        GNT_INST: begin
          i_ret_valid = m_ret_valid;
          i_ret_last  = m_ret_last;
          i_ret_data  = m_ret_data;
        end
        GNT_DATA: begin
          d_ret_valid = m_ret_valid;
          d_ret_last  = m_ret_last;
          d_ret_data  = m_ret_data;
        end
        default: ;
      endcase
    end
  end

  assign busy           = busy_q;
  assign dbg_state      = state_q;
  assign dbg_grant      = grant_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level arbitration model and a bridge-side data scoreboard.
module tb_cache_rd_arbiter;

  localparam int LIMIT = 2;

  logic        clock;
  logic        reset;
  logic        i_rd_req, d_rd_req;
  logic [2:0]  i_rd_type, d_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic        i_rd_rdy, d_rd_rdy;
  logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0] i_ret_data, d_ret_data;
  logic        m_rd_req;
  logic [2:0]  m_rd_type;
  logic [31:0] m_rd_addr;
  logic        m_rd_rdy, m_ret_valid, m_ret_last;
  logic [31:0] m_ret_data;
  logic        wr_buf_empty;
  logic        busy;
  logic [1:0]  dbg_state, dbg_grant;
  logic [7:0]  dbg_starve_cnt;

  int n_vec;
  int n_err;
  int model_cnt;
  logic [31:0] exp_q[$];
  int          gnt_exp_q[$];

  cache_rd_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
    .wr_buf_empty(wr_buf_empty), .busy(busy),
    .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [106:0] obs_now();
    return {busy, m_rd_req, m_rd_type, m_rd_addr, i_rd_rdy, d_rd_rdy,
            i_ret_valid, i_ret_last, i_ret_data, d_ret_valid, d_ret_last, d_ret_data};
  endfunction

  function automatic logic [106:0] mk_exp(logic b, logic mr, logic [2:0] mt, logic [31:0] ma,
                                          logic ir, logic dr, logic iv, logic il, logic [31:0] id,
                                          logic dv, logic dl, logic [31:0] dd);
    return {b, mr, mt, ma, ir, dr, iv, il, id, dv, dl, dd};
  endfunction

  function automatic logic [2:0] rand_type();
    logic [2:0] t;
    if ($urandom_range(0, 1) == 1) return 3'b100;
    t = 3'($urandom_range(0, 7));
    if (t == 3'b100) t = 3'b010;
    return t;
  endfunction

  // Reference arbitration: 0 = no grant, 1 = icache, 2 = dcache.
  function automatic int model_pick(logic ir, logic [2:0] it, logic dr, logic [2:0] dt,
                                    logic wb, int cnt);
    bit ie, de;
    ie = ir && (it == 3'b100 || wb);
    de = dr && (dt == 3'b100 || wb);
    if (de && (!ie || cnt < LIMIT)) return 2;
    if (ie) return 1;
    return 0;
  endfunction

  // driver: one IDLE cycle with the caller's inputs already applied
  task automatic arb_idle(output int who);
    logic [106:0] ev;
    who = model_pick(i_rd_req, i_rd_type, d_rd_req, d_rd_type, wr_buf_empty, model_cnt);
    #1;
    ev = '0;
    n_vec++;
    if (obs_now() !== ev) begin
      n_err++;
      $display("FAIL idle_outputs: got %h exp %h", obs_now(), ev);
    end
    if (who == 2 && i_rd_req) model_cnt = (model_cnt + 1 > LIMIT) ? LIMIT : model_cnt + 1;
    else if (who != 0) model_cnt = 0;
    tick();
  endtask

  // driver: bridge side of one granted transaction, from REQ through the last beat
  task automatic serve(input int who, input int rdy_wait, input int gap_max,
                       input bit drop, input bit wb_rand, output int seen);
    logic [2:0]   et;
    logic [31:0]  ea, d;
    logic [106:0] ev;
    int nb, gaps;
    bit ii, dd;
    ii = (who == 1);
    dd = (who == 2);
    et = ii ? i_rd_type : d_rd_type;
    ea = ii ? i_rd_addr : d_rd_addr;
    nb = (et == 3'b100) ? 4 : 1;
    seen = 0;
    for (int w = 0; w <= rdy_wait; w++) begin
      m_rd_rdy    = (w == rdy_wait);
      m_ret_valid = 1'($urandom_range(0, 1));
      m_ret_last  = 1'($urandom_range(0, 1));
      m_ret_data  = $urandom;
      if (wb_rand) wr_buf_empty = 1'($urandom_range(0, 1));
      #1;
      ev = mk_exp(1'b1, 1'b1, et, ea, ii && m_rd_rdy, dd && m_rd_rdy,
                  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (obs_now() !== ev) begin
        n_err++;
        $display("FAIL req_phase: got %h exp %h", obs_now(), ev);
      end
      n_vec++;
      if (dbg_starve_cnt !== 8'(model_cnt)) begin
        n_err++;
        $display("FAIL starve_cnt: got %0d exp %0d", dbg_starve_cnt, model_cnt);
      end
      if (m_rd_rdy && i_rd_rdy) seen = 1;
      else if (m_rd_rdy && d_rd_rdy) seen = 2;
      tick();
    end
    m_rd_rdy = 1'b0;
    if (drop && ii) i_rd_req = 1'b0;
    if (drop && dd) d_rd_req = 1'b0;
    for (int b = 0; b < nb; b++) begin
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        m_ret_valid = 1'b0;
        m_ret_last  = 1'b0;
        m_ret_data  = $urandom;
        if (wb_rand) wr_buf_empty = 1'($urandom_range(0, 1));
        #1;
        ev = mk_exp(1'b1, 1'b0, 3'b0, 32'h0, 1'b0, 1'b0,
                    1'b0, 1'b0, ii ? m_ret_data : 32'h0, 1'b0, 1'b0, dd ? m_ret_data : 32'h0);
        n_vec++;
        if (obs_now() !== ev) begin
          n_err++;
          $display("FAIL resp_gap: got %h exp %h", obs_now(), ev);
        end
        tick();
      end
      m_ret_valid = 1'b1;
      m_ret_last  = (b == nb - 1);
      m_ret_data  = $urandom;
      exp_q.push_back(m_ret_data);
      if (wb_rand) wr_buf_empty = 1'($urandom_range(0, 1));
      #1;
      d = exp_q.pop_front();
      ev = mk_exp(1'b1, 1'b0, 3'b0, 32'h0, 1'b0, 1'b0,
                  ii, ii && (b == nb - 1), ii ? d : 32'h0,
                  dd, dd && (b == nb - 1), dd ? d : 32'h0);
      n_vec++;
      if (obs_now() !== ev) begin
        n_err++;
        $display("FAIL resp_beat%0d: got %h exp %h", b, obs_now(), ev);
      end
      tick();
    end
    m_ret_valid = 1'b0;
    m_ret_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_ret_valid = 1'b1;
    m_ret_data  = 32'hdead_beef;
    tick();
    tick();
    n_vec++;
    if (obs_now() !== '0 || dbg_starve_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h/%0d exp 0/0", obs_now(), dbg_starve_cnt);
    end
    reset = 1'b0;
    m_ret_valid = 1'b0;
    model_cnt = 0;
    tick();
  endtask

  task automatic test_icache_line();
    int who, seen;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h100;
    wr_buf_empty = 1'b1;
    arb_idle(who);
    serve(who, 2, 1, 1'b1, 1'b0, seen);
    n_vec++;
    if (seen !== 1) begin
      n_err++;
      $display("FAIL icache_grant: got %0d exp 1", seen);
    end
    arb_idle(who);
  endtask

  task automatic test_grant_order(input string name, input int n, input bit hold);
    int who, seen, e;
    for (int k = 0; k < n; k++) begin
      arb_idle(who);
      serve(who, $urandom_range(0, 1), 0, !hold, 1'b0, seen);
      e = gnt_exp_q.pop_front();
      n_vec++;
      if (seen !== e) begin
        n_err++;
        $display("FAIL %s_grant%0d: got %0d exp %0d", name, k, seen, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h400;
    d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h500;
    gnt_exp_q = '{2, 1};
    test_grant_order("simul", 2, 1'b0);
  endtask

  task automatic test_starvation();
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h600;
    d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h700;
    gnt_exp_q = '{2, 2, 1, 2};
    test_grant_order("starve", 4, 1'b1);
    i_rd_req = 1'b0;
    d_rd_req = 1'b0;
  endtask

  task automatic test_uncached_hold();
    int who;
    d_rd_req = 1'b1; d_rd_type = 3'b010; d_rd_addr = 32'h2000;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h3000;
    wr_buf_empty = 1'b0;
    gnt_exp_q = '{1};
    test_grant_order("unc_i", 1, 1'b0);
    arb_idle(who);
    arb_idle(who);
    wr_buf_empty = 1'b1;
    gnt_exp_q = '{2};
    test_grant_order("unc_d", 1, 1'b0);
  endtask

  task automatic test_stray();
    int who;
    i_rd_req = 1'b0;
    d_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_ret_valid = 1'b1;
      m_ret_last  = k[0];
      m_ret_data  = $urandom;
      arb_idle(who);
    end
    m_ret_valid = 1'b0;
    m_ret_last  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int who;
    logic [106:0] ev;
    logic [31:0] d;
    d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h8000;
    i_rd_req = 1'b1; i_rd_type = 3'b001; i_rd_addr = 32'h9000;
    wr_buf_empty = 1'b0;
    arb_idle(who);
    m_rd_rdy = 1'b1;
    #1;
    ev = mk_exp(1'b1, 1'b1, 3'b100, 32'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (obs_now() !== ev || dbg_starve_cnt !== 8'(model_cnt)) begin
      n_err++;
      $display("FAIL rst_req: got %h/%0d exp %h/%0d", obs_now(), dbg_starve_cnt, ev, model_cnt);
    end
    tick();
    m_rd_rdy = 1'b0;
    d_rd_req = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_ret_valid = 1'b1;
      m_ret_last  = 1'b0;
      m_ret_data  = $urandom;
      exp_q.push_back(m_ret_data);
      #1;
      d = exp_q.pop_front();
      ev = mk_exp(1'b1, 1'b0, 3'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, d);
      n_vec++;
      if (obs_now() !== ev) begin
        n_err++;
        $display("FAIL rst_beat%0d: got %h exp %h", b, obs_now(), ev);
      end
      tick();
    end
    reset = 1'b1;
    i_rd_req = 1'b0;
    m_ret_valid = 1'b0;
    m_ret_data  = 32'h0;
    tick();
    reset = 1'b0;
    model_cnt = 0;
    for (int b = 0; b < 2; b++) begin
      m_ret_valid = 1'b1;
      m_ret_last  = (b == 1);
      m_ret_data  = $urandom;
      #1;
      n_vec++;
      if (obs_now() !== '0 || dbg_starve_cnt !== 8'd0) begin
        n_err++;
        $display("FAIL rst_after%0d: got %h/%0d exp 0/0", b, obs_now(), dbg_starve_cnt);
      end
      tick();
    end
    m_ret_valid = 1'b0;
    m_ret_last  = 1'b0;
    wr_buf_empty = 1'b1;
  endtask

  task automatic test_random(input int n);
    int who, seen, k;
    for (int t = 0; t < n; t++) begin
      if (!i_rd_req && $urandom_range(0, 1) == 1) begin
        i_rd_req = 1'b1; i_rd_type = rand_type(); i_rd_addr = $urandom & 32'hffff_fffc;
      end
      if (!d_rd_req && ($urandom_range(0, 1) == 1 || !i_rd_req)) begin
        d_rd_req = 1'b1; d_rd_type = rand_type(); d_rd_addr = $urandom & 32'hffff_fffc;
      end
      wr_buf_empty = 1'($urandom_range(0, 1));
      who = 0;
      k = 0;
      while (who == 0 && k < 6) begin
        m_ret_valid = 1'($urandom_range(0, 1));
        m_ret_last  = 1'($urandom_range(0, 1));
        m_ret_data  = $urandom;
        arb_idle(who);
        k++;
        if (who == 0) wr_buf_empty = (k >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      m_ret_valid = 1'b0;
      if (who != 0) begin
        serve(who, $urandom_range(0, 2), $urandom_range(0, 1), 1'b1, 1'b1, seen);
        n_vec++;
        if (seen !== who) begin
          n_err++;
          $display("FAIL rand_grant%0d: got %0d exp %0d", t, seen, who);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_cnt = 0;
    reset = 1'b1;
    i_rd_req = 1'b0; i_rd_type = 3'b0; i_rd_addr = 32'h0;
    d_rd_req = 1'b0; d_rd_type = 3'b0; d_rd_addr = 32'h0;
    m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = 32'h0;
    wr_buf_empty = 1'b1;

    test_reset();
    test_icache_line();
    test_simultaneous();
    test_starvation();
    test_uncached_hold();
    test_stray();
    test_reset_mid();
    test_random(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_rd_arbiter.md
# cache_rd_arbiter

Shares one cache-side read channel between the icache and dcache refill/uncached-read ports and feeds it to a single-read-port memory bridge. One read transaction is outstanding at a time. The dcache has priority, and a starvation counter guarantees icache progress. Uncached reads are held back until the bridge write buffer drains, which preserves read-after-write ordering.

## Interface
- STARVE_LIMIT, 8: consecutive dcache grants allowed while an icache request waits (1..255).
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_rd_req / d_rd_req  in  1  read request from icache / dcache; held until the matching rd_rdy
- i_rd_type / d_rd_type  in  3  3'b100 = cache line (4-beat burst); any other value = uncached single beat
- i_rd_addr / d_rd_addr  in  32  read address
- i_rd_rdy / d_rd_rdy  out  1  request accepted
- i_ret_valid / d_ret_valid  out  1  return beat valid
- i_ret_last / d_ret_last  out  1  final return beat
- i_ret_data / d_ret_data  out  32  return data
- m_rd_req  out  1  request to bridge
- m_rd_type  out  3  forwarded type
- m_rd_addr  out  32  forwarded address
- m_rd_rdy  in  1  bridge accepts request
- m_ret_valid, m_ret_last  in  1  bridge return beat / last beat
- m_ret_data  in  32  bridge return data
- wr_buf_empty  in  1  bridge write buffer empty
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, RESP. Grant register: NONE, INST, DATA.
- Eligibility: a request is eligible if its rd_type == 3'b100, or if wr_buf_empty == 1.
- IDLE, with at least one eligible request:
  - Grant DATA if d is eligible and (i is not eligible or starve_cnt < STARVE_LIMIT).
  - Otherwise grant INST.
  - Go to REQ.
- IDLE, no eligible request: stay in IDLE.
- Starvation counter (8-bit, saturating at STARVE_LIMIT):
  - DATA grant while i_rd_req is pending: starve_cnt + 1.
  - INST grant: starve_cnt cleared.
  - DATA grant with no i_rd_req pending: starve_cnt cleared.
- REQ: m_rd_req, m_rd_type and m_rd_addr are combinationally muxed from the granted requester. The granted requester's rd_rdy = m_rd_rdy. The other requester's rd_rdy = 0. On m_rd_req && m_rd_rdy, go to RESP.
- RESP: m_ret_valid, m_ret_last and m_ret_data are routed to the granted requester only; the other requester's ret outputs are 0. On m_ret_valid && m_ret_last, go to IDLE and set grant to NONE.
- m_ret_valid received in IDLE or REQ is dropped and never forwarded.
- wr_buf_empty is sampled only at arbitration in IDLE. It has no effect once a grant is made.
- Reset mid-transaction: state = IDLE, grant = NONE, starve_cnt = 0. Subsequent stray return beats are dropped.

## Timing
- Reset values: every output is 0 (m_rd_req, m_rd_type, m_rd_addr, both rd_rdy, all ret_*, busy).
- Arbitration takes 1 cycle. A request first seen in IDLE at cycle N drives m_rd_req at cycle N+1.
- rd_rdy is combinational from m_rd_rdy, with zero added latency.
- Return path is combinational, with zero added latency.
- Back-to-back: the cycle after the last beat is IDLE and arbitrates. Minimum spacing between request handshakes is 3 cycles with a 1-beat return.
- Simultaneous i and d requests in IDLE follow the priority rule above. The losing request must remain asserted and is considered at the next IDLE.
- busy is registered and equals (state != IDLE).

## Test plan
- Single icache line read at 0x100: m_rd_req asserts 1 cycle later with addr 0x100 and type 3'b100. i_rd_rdy mirrors m_rd_rdy. 4 beats are forwarded to i_ret_*, with i_ret_last on beat 4. d_ret_valid stays 0 throughout. busy falls the cycle after beat 4.
- Simultaneous i and d line requests in IDLE: DATA is granted first. INST is granted on the next IDLE, after d_ret_last.
- Starvation, STARVE_LIMIT = 2: d_rd_req is held continuously and i_rd_req is held continuously. Grant order is DATA, DATA, INST, DATA.
- Uncached d read (type 3'b010) with wr_buf_empty = 0 for 5 cycles: no m_rd_req during those cycles, and a pending i line request is granted meanwhile. The d request is granted in the first IDLE after wr_buf_empty = 1.
- Reset asserted in RESP after beat 2: all outputs are 0 next cycle and state is IDLE. Beats 3–4 from the bridge are not forwarded to either cache.
- Stray m_ret_valid = 1 in IDLE with no requests: i_ret_valid and d_ret_valid stay 0, and state stays IDLE.
